// File: rtl/skinny_isw1_pkg.sv
// Shared constants, state encoding and linear S-box helpers for the serial
// first-order masked SKINNY S-box layer.
package skinny_isw1_pkg;

   localparam int NBYTES   = 16;
   localparam int SBOX_LAT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WAIT  = 2'd2,
      STORE = 2'd3
   } state_e;

   // Bit permutation applied between the four nonlinear rounds of S8.
   function automatic logic [7:0] sbox_perm(input logic [7:0] x);
      return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
   endfunction

   // Final output swap of bits 1 and 2.
   function automatic logic [7:0] sbox_swap(input logic [7:0] x);
      return {x[7:3], x[1], x[2], x[0]};
   endfunction

endpackage

// File: rtl/skinny_sbox8_isw1_pini_non_pipelined.sv
// Two-share SKINNY 8-bit S-box: four masked NOR/XOR rounds, each split into a
// product stage and a compression stage, giving an 8-cycle settle time.
module skinny_sbox8_isw1_pini_non_pipelined
   import skinny_isw1_pkg::*;
(
   input  logic        clk,
   input  logic [7:0]  si1,
   input  logic [7:0]  si0,
   input  logic [15:0] r,
   output logic [7:0]  bo1,
   output logic [7:0]  bo0
);

   logic [4:0][7:0] lin0;
   logic [4:0][7:0] lin1;

   assign lin0[0] = si0;
   assign lin1[0] = si1;

   for (genvar k = 0; k < 4; k++) begin : g_round
      logic [1:0] a0, a1, b0, b1, ra, rb, c0, c1;
      logic [7:0] m0, m1;
      (* keep = "true" *) logic [7:0] x0_q, x1_q, y0_q, y1_q;
      (* keep = "true" *) logic [1:0] z0_q, z1_q, t01_q, t10_q;

      // The complemented NOR inputs are negated on share 0 only.
      assign a0 = ~{lin0[k][6], lin0[k][2]};
      assign a1 =  {lin1[k][6], lin1[k][2]};
      assign b0 = ~{lin0[k][7], lin0[k][3]};
      assign b1 =  {lin1[k][7], lin1[k][3]};
      assign ra = {r[4*k+2], r[4*k]};
      assign rb = {r[4*k+3], r[4*k+1]};

      always_ff @(posedge clk) begin
         x0_q  <= lin0[k];
         x1_q  <= lin1[k];
         z0_q  <= (a0 & b0) ^ ra ^ rb;
         z1_q  <= a1 & b1;
         t01_q <= (a0 & b1) ^ ra;
         t10_q <= (a1 & b0) ^ rb;
      end

      assign c0 = z0_q;
      assign c1 = z1_q ^ t01_q ^ t10_q;
      assign m0 = x0_q ^ {3'b000, c0[1], 3'b000, c0[0]};
      assign m1 = x1_q ^ {3'b000, c1[1], 3'b000, c1[0]};

      always_ff @(posedge clk) begin
         y0_q <= (k == 3) ? sbox_swap(m0) : sbox_perm(m0);
         y1_q <= (k == 3) ? sbox_swap(m1) : sbox_perm(m1);
      end

      assign lin0[k+1] = y0_q;
      assign lin1[k+1] = y1_q;
   end

   assign bo0 = lin0[4];
   assign bo1 = lin1[4];

endmodule

// File: rtl/skinny_sbox_layer_isw1_serial.sv
// Serial masked SKINNY S-box layer: bytes 0..NBYTES-1 pass one at a time
// through a single two-share S-box, each with its own fresh 16-bit mask.
//
// state | meaning
// IDLE  | waiting for start; so1/so0 keep the last result
// LOAD  | waiting on rnd_valid to load byte idx and mask into holding regs
// WAIT  | S-box settling for SBOX_LAT cycles
// STORE | S-box output shares written to byte idx of so1/so0
module skinny_sbox_layer_isw1_serial #(
   parameter int NBYTES   = skinny_isw1_pkg::NBYTES,
   parameter int SBOX_LAT = skinny_isw1_pkg::SBOX_LAT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [8*NBYTES-1:0] si1,
   input  logic [8*NBYTES-1:0] si0,
   input  logic [15:0]         rnd,
   input  logic                rnd_valid,
   output logic                rnd_ready,
   output logic [8*NBYTES-1:0] so1,
   output logic [8*NBYTES-1:0] so0,
   output logic                busy,
   output logic                done
);
   import skinny_isw1_pkg::*;

   localparam int CW = $clog2(SBOX_LAT + 1);
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   (* keep = "true" *) state_e              state_q;
   (* keep = "true" *) logic [8*NBYTES-1:0] st1_q, st0_q;
   (* keep = "true" *) logic [IW-1:0]       idx_q;
   (* keep = "true" *) logic [CW-1:0]       wcnt_q;
   (* keep = "true" *) logic [7:0]          hold1_q, hold0_q;
   (* keep = "true" *) logic [15:0]         hold_rnd_q;
   (* keep = "true" *) logic [8*NBYTES-1:0] so1_q, so0_q;
   (* keep = "true" *) logic                done_q;
   logic [7:0] bo1, bo0;

   skinny_sbox8_isw1_pini_non_pipelined u_sbox (
      .clk (clk),
      .si1 (hold1_q),
      .si0 (hold0_q),
      .r   (hold_rnd_q),
      .bo1 (bo1),
      .bo0 (bo0)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         st1_q      <= '0;
         st0_q      <= '0;
         idx_q      <= '0;
         wcnt_q     <= '0;
         hold1_q    <= '0;
         hold0_q    <= '0;
         hold_rnd_q <= '0;
         so1_q      <= '0;
         so0_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               st1_q   <= si1;
               st0_q   <= si0;
               idx_q   <= '0;
               state_q <= LOAD;
            end
            LOAD: if (rnd_valid) begin
               hold1_q    <= st1_q[8*idx_q +: 8];
               hold0_q    <= st0_q[8*idx_q +: 8];
               hold_rnd_q <= rnd;
               wcnt_q     <= '0;
               state_q    <= WAIT;
            end
            WAIT: begin
               if (wcnt_q == CW'(SBOX_LAT - 1)) state_q <= STORE;
               else                             wcnt_q  <= wcnt_q + 1'b1;
            end
            STORE: begin
               so1_q[8*idx_q +: 8] <= bo1;
               so0_q[8*idx_q +: 8] <= bo0;
               if (idx_q == IW'(NBYTES - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= LOAD;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rnd_ready = (state_q == LOAD) && rnd_valid;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign so1       = so1_q;
   assign so0       = so0_q;

endmodule

// File: tb/tb_skinny_sbox_layer_isw1_serial.sv
// Table-driven bench for the serial masked SKINNY S-box layer with a
// scoreboard of expected layer results and latencies.
module tb_skinny_sbox_layer_isw1_serial;

   localparam int NB = 16;
   localparam int W  = 8 * NB;

   logic         clk, rst_n, start, rnd_valid, rnd_ready, busy, done;
   logic [W-1:0] si1, si0, so1, so0;
   logic [15:0]  rnd;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [W-1:0] state;
      logic [W-1:0] exp_res;
      int           stall_byte;
      int           stall_len;
      int           restart_at;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      int           lat;
   } sb_t;

   vec_t vecs[6];
   sb_t  sb_q[$];

   skinny_sbox_layer_isw1_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .si1       (si1),
      .si0       (si0),
      .rnd       (rnd),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .so1       (so1),
      .so0       (so0),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Unmasked reference S8 in the shift-and-mask form of the SKINNY reference code.
   function automatic logic [7:0] sbox_ref(input logic [7:0] xi);
      logic [7:0] x;
      x = xi;
      for (int k = 0; k < 4; k++) begin
         x = (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
         if (k < 3)
            x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
                ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
      end
      return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
   endfunction

   function automatic logic [W-1:0] layer_ref(input logic [W-1:0] s);
      logic [W-1:0] o;
      o = '0;
      for (int i = 0; i < NB; i++) o[8*i +: 8] = sbox_ref(s[8*i +: 8]);
      return o;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
      n_checks++;
      if (act !== exp_v) $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      else n_pass++;
   endtask

   task automatic run_op(input vec_t v, input int abort_at);
      int           n, pulses;
      logic         hv, pend;
      logic [7:0]   hb, pb;
      logic [15:0]  hr, pr;
      logic [W-1:0] mask;
      sb_t          e;
      n = 0; pulses = 0; hv = 1'b0; pend = 1'b0;
      hb = '0; pb = '0; hr = '0; pr = '0;
      for (int i = 0; i < 50 && busy; i++) begin
         @(posedge clk); #1;
      end
      chk("idle_before_start", W'(busy), '0);
      mask  = {$urandom, $urandom, $urandom, $urandom};
      si1   = mask;
      si0   = v.state ^ mask;
      start = 1'b1;
      rnd_valid = 1'b0;
      e.res = v.exp_res;
      e.lat = v.lat;
      sb_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      si1   = {$urandom, $urandom, $urandom, $urandom};
      si0   = {$urandom, $urandom, $urandom, $urandom};
      while (1) begin
         if (pend) begin
            hv = 1'b1; hb = pb; hr = pr; pend = 1'b0;
         end
         if (hv)
            chk("holding_regs", W'({dut.hold1_q ^ dut.hold0_q, dut.hold_rnd_q}), W'({hb, hr}));
         if (done) begin
            if (sb_q.size() > 0) e = sb_q.pop_front();
            chk("done_latency", W'(n), W'(e.lat));
            chk("layer_result", so1 ^ so0, e.res);
            chk("rnd_ready_pulses", W'(pulses), W'(NB));
            chk("busy_at_done", W'(busy), '0);
            @(posedge clk); #1;
            chk("done_one_cycle", W'(done), '0);
            chk("result_held_idle", so1 ^ so0, e.res);
            return;
         end
         if (n == abort_at) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("abort_busy", W'(busy), '0);
            chk("abort_so1", so1, '0);
            chk("abort_so0", so0, '0);
            chk("abort_done_ready", W'({done, rnd_ready}), '0);
            chk("abort_holding", W'({dut.hold1_q, dut.hold0_q, dut.hold_rnd_q}), '0);
            rst_n = 1'b1;
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            return;
         end
         if (n >= 400) begin
            n_checks++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done at %0d", n, v.lat);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
         end
         start = (n == v.restart_at);
         if (start) begin
            si1 = ~si1;
            si0 = si0 ^ {W{1'b1}};
         end
         rnd_valid = !(v.stall_byte >= 0 && n >= 10 * v.stall_byte &&
                       n < 10 * v.stall_byte + v.stall_len);
         rnd = 16'($urandom);
         #1;
         if (rnd_ready) begin
            pend = 1'b1;
            pb   = (pulses < NB) ? v.state[8*pulses +: 8] : 8'h00;
            pr   = rnd;
            pulses++;
         end
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      logic [W-1:0] pat;
      rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b1; rnd = '0; si1 = '0; si0 = '0;

      vecs[0] = '{state: '0,           exp_res: {16{8'h65}}, stall_byte: -1, stall_len: 0, restart_at: -1, lat: 160};
      vecs[1] = '{state: {16{8'hFF}},  exp_res: {16{8'hFF}}, stall_byte: -1, stall_len: 0, restart_at: -1, lat: 160};
      vecs[2] = '{state: W'(8'h01),    exp_res: {{15{8'h65}}, 8'h4C}, stall_byte: -1, stall_len: 0, restart_at: -1, lat: 160};
      vecs[3] = '{state: '0,           exp_res: {16{8'h65}}, stall_byte: 5, stall_len: 3, restart_at: -1, lat: 163};
      for (int i = 0; i < NB; i++) pat[8*i +: 8] = 8'(i * 29) ^ 8'h3C;
      vecs[4] = '{state: pat, exp_res: layer_ref(pat), stall_byte: -1, stall_len: 0, restart_at: 37, lat: 160};
      pat = {$urandom, $urandom, $urandom, $urandom};
      vecs[5] = '{state: pat, exp_res: layer_ref(pat), stall_byte: 15, stall_len: 1, restart_at: -1, lat: 161};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_so1", so1, '0);
      chk("reset_so0", so0, '0);
      chk("reset_busy_done_ready", W'({busy, done, rnd_ready}), '0);
      rst_n = 1'b1;
      rnd_valid = 1'b0;

      for (int i = 0; i < 6; i++) run_op(vecs[i], -1);
      run_op(vecs[0], 74);
      run_op(vecs[2], -1);
      chk("scoreboard_empty", W'(sb_q.size()), '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/skinny_sbox_layer_isw1_serial.md
SKINNY_SBOX_LAYER_ISW1_SERIAL -- requirements
Module: skinny_sbox_layer_isw1_serial

Interface
REQ-001 SHALL have parameter NBYTES, default 16, the number of state bytes processed per layer call.
REQ-002 SHALL have parameter SBOX_LAT, default 8, the number of cycles from stable S-box input to valid S-box output.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to apply the S-box layer; sampled only in IDLE.
REQ-006 SHALL have port si1, input, 8*NBYTES bits: state share 1; sampled when start is accepted.
REQ-007 SHALL have port si0, input, 8*NBYTES bits: state share 0; sampled when start is accepted.
REQ-008 SHALL have port rnd, input, 16 bits: fresh mask for one S-box evaluation.
REQ-009 SHALL have port rnd_valid, input, 1 bit: rnd carries fresh randomness.
REQ-010 SHALL have port rnd_ready, output, 1 bit: rnd is consumed this cycle.
REQ-011 SHALL have port so1, output, 8*NBYTES bits: result share 1; registered.
REQ-012 SHALL have port so0, output, 8*NBYTES bits: result share 0; registered.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when so1/so0 hold the complete layer result.

Function
REQ-015 SHALL have FSM states IDLE, LOAD, WAIT and STORE.
REQ-016 IDLE: on start=1, SHALL capture si1/si0 into internal state registers, clear the byte index to 0, and move to LOAD.
REQ-017 LOAD: if rnd_valid=1, SHALL assert rnd_ready for that cycle, write byte[idx] of both shares and rnd into the holding registers, clear the wait counter, and move to WAIT.
REQ-018 LOAD: if rnd_valid=0, SHALL stay in LOAD with rnd_ready=0 and the holding registers unchanged.
REQ-019 Holding registers (2x8-bit shares, 16-bit mask) SHALL drive the S-box instance directly and SHALL stay constant from the LOAD write until STORE completes.
REQ-020 WAIT SHALL last exactly SBOX_LAT cycles, counted by a wait counter of width clog2(SBOX_LAT+1), then move to STORE.
REQ-021 STORE: SHALL write the S-box output shares into so1/so0 byte[idx].
REQ-022 STORE: if idx=NBYTES-1, SHALL pulse done and return to IDLE; otherwise SHALL increment idx and return to LOAD.
REQ-023 Byte i SHALL be bits [8i+7:8i]; bytes SHALL be processed in order 0 to NBYTES-1.
REQ-024 With no randomness stalls, done SHALL occur exactly NBYTES*(SBOX_LAT+2) cycles after start acceptance (160 at defaults); each stall cycle SHALL add one cycle.
REQ-025 start while busy=1 SHALL be ignored; changes on si1/si0 after acceptance SHALL have no effect.
REQ-026 rnd_ready SHALL be high only in LOAD with rnd_valid=1; each rnd word SHALL be used for exactly one byte.
REQ-027 The two shares SHALL never be combined in any logic; each holding register SHALL be written only from the same share index.
REQ-028 so1/so0 SHALL keep their last value in IDLE until the next STORE overwrites them.

Reset
REQ-029 With rst_n=0 at a clock edge, the block SHALL enter IDLE from any state, including mid-operation.
REQ-030 Reset SHALL clear to 0: idx, wait counter, holding registers, internal state registers, so1, so0, done, rnd_ready and busy.
REQ-031 Partial results of an aborted operation SHALL not be retained.
REQ-032 The S-box instance pipeline is not reset; its output SHALL be ignored until SBOX_LAT cycles after a LOAD.

Structure
REQ-033 NBYTES, SBOX_LAT and the FSM state encoding SHALL live in a shared package, skinny_isw1_pkg.
REQ-034 The block SHALL instantiate exactly one sub-module, skinny_sbox8_isw1_pini_non_pipelined (inputs si1/si0/r/clk, outputs bo1/bo0).
REQ-035 All holding and state registers SHALL carry the no-register-removal synthesis attribute.

Verification
REQ-036 Bench SHALL cover: state all 0x00, random shares, rnd_valid always 1 -> so1^so0 = 0x65 in every byte; done at cycle 160; 16 rnd_ready pulses.
REQ-037 Bench SHALL cover: state all 0xFF -> so1^so0 = 0xFF in every byte.
REQ-038 Bench SHALL cover: byte0=0x01, other bytes 0x00 -> byte0=0x4C, other bytes 0x65.
REQ-039 Bench SHALL cover: rnd_valid low for 3 cycles before byte 5 -> correct result; done at cycle 163; holding registers stable throughout.
REQ-040 Bench SHALL cover: rst_n=0 in WAIT of byte 7 -> next cycle IDLE, busy=0, so1=so0=0; a restarted run completes correctly.
REQ-041 Bench SHALL cover: start pulsed again mid-run with different si -> ignored; result matches the first input.
